// File: rtl/otp_ctrl_pkg.sv
// Shared definitions for the OTP session controller.
//   - FSM state encodings (IDLE, ENTRY, CHECK, GRANT, LOCKED)
//   - NIB_W: width of one OTP / user digit
//   - width helpers for the attempt counter, digit/scan counters and timers
package otp_ctrl_pkg;

    localparam int unsigned NIB_W = 4;
    localparam int unsigned ST_W  = 3;

    localparam logic [ST_W-1:0] ST_IDLE   = 3'd0;
    localparam logic [ST_W-1:0] ST_ENTRY  = 3'd1;
    localparam logic [ST_W-1:0] ST_CHECK  = 3'd2;
    localparam logic [ST_W-1:0] ST_GRANT  = 3'd3;
    localparam logic [ST_W-1:0] ST_LOCKED = 3'd4;

    // Bits needed to hold 0..max_att
    function automatic int unsigned att_w(input int unsigned max_att);
        return (max_att < 1) ? 1 : $clog2(max_att + 1);
    endfunction

    // Bits needed to hold 0..n-1 (at least one bit)
    function automatic int unsigned cnt_w(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    // Shared timer wide enough for both the entry timeout and the lockout
    function automatic int unsigned tmr_w(input int unsigned a, input int unsigned b);
        return cnt_w((a > b) ? a : b);
    endfunction

endpackage

// File: rtl/otp_disp_scan.sv
// Multiplexed display scan for the OTP and user-entry digits.
//   clk, reset_n    : clock, synchronous active-low reset
//   otp_in          : latched OTP, digit 0 in the MS nibble
//   entry_in        : entered digits, same layout
//   an              : anode select, active-low one-hot, digit 0 first
//   disp_otp_nib    : otp_in nibble for the active anode
//   disp_user_nib   : entry_in nibble for the active anode
module otp_disp_scan
    import otp_ctrl_pkg::*;
#(
    parameter int unsigned DIGITS      = 2,
    parameter int unsigned REFRESH_DIV = 16
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [NIB_W*DIGITS-1:0] otp_in,
    input  logic [NIB_W*DIGITS-1:0] entry_in,
    output logic [DIGITS-1:0]       an,
    output logic [NIB_W-1:0]        disp_otp_nib,
    output logic [NIB_W-1:0]        disp_user_nib
);

    localparam int unsigned REF_W = cnt_w(REFRESH_DIV);
    localparam int unsigned SEL_W = cnt_w(DIGITS);

    logic [REF_W-1:0]  ref_q, ref_d;
    logic [SEL_W-1:0]  sel_q, sel_d;
    logic [DIGITS-1:0] an_q, an_d;
    logic [NIB_W-1:0]  otp_nib_q, otp_nib_d;
    logic [NIB_W-1:0]  user_nib_q, user_nib_d;

    // Dwell counter, anode rotation and nibble select (all aligned to sel_d)
    always_comb begin
        ref_d      = ref_q + REF_W'(1);
        sel_d      = sel_q;
        an_d       = '1;
        otp_nib_d  = '0;
        user_nib_d = '0;
        if (ref_q == REF_W'(REFRESH_DIV - 1)) begin
            ref_d = '0;
            sel_d = (sel_q == SEL_W'(DIGITS - 1)) ? '0 : sel_q + SEL_W'(1);
        end
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (sel_d == SEL_W'(i)) begin
                an_d[i]    = 1'b0;
                otp_nib_d  = otp_in[(int'(DIGITS) - 1 - i) * NIB_W +: NIB_W];
                user_nib_d = entry_in[(int'(DIGITS) - 1 - i) * NIB_W +: NIB_W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            ref_q      <= '0;
            sel_q      <= '0;
            an_q       <= ~DIGITS'(1);
            otp_nib_q  <= '0;
            user_nib_q <= '0;
        end else begin
            ref_q      <= ref_d;
            sel_q      <= sel_d;
            an_q       <= an_d;
            otp_nib_q  <= otp_nib_d;
            user_nib_q <= user_nib_d;
        end
    end

    assign an            = an_q;
    assign disp_otp_nib  = otp_nib_q;
    assign disp_user_nib = user_nib_q;

endmodule

// File: rtl/otp_session_ctrl.sv
// OTP session sequencer: captures an OTP from the LFSR, collects DIGITS user
// digits, compares, and issues grant / fail / expired pulses with an attempt
// limit and timed lockout. Also drives the multiplexed display scan.
//   otp_latch / user_latch / user_in / lfsr_code : session inputs
//   otp_q, entry_q                               : latched OTP and entry
//   grant, fail, expired                         : one-cycle result pulses
//   locked, busy, attempts_left                  : session status levels
//   an, disp_otp_nib, disp_user_nib              : display scan outputs
module otp_session_ctrl
    import otp_ctrl_pkg::*;
#(
    parameter int unsigned DIGITS       = 2,
    parameter int unsigned MAX_ATTEMPTS = 3,
    parameter int unsigned TIMEOUT_CYC  = 1000,
    parameter int unsigned LOCK_CYC     = 5000,
    parameter int unsigned REFRESH_DIV  = 16
) (
    input  logic                            clk,
    input  logic                            reset_n,
    input  logic                            otp_latch,
    input  logic                            user_latch,
    input  logic [NIB_W-1:0]                user_in,
    input  logic [NIB_W*DIGITS-1:0]         lfsr_code,
    output logic [NIB_W*DIGITS-1:0]         otp_q,
    output logic [NIB_W*DIGITS-1:0]         entry_q,
    output logic                            grant,
    output logic                            fail,
    output logic                            expired,
    output logic                            locked,
    output logic                            busy,
    output logic [att_w(MAX_ATTEMPTS)-1:0]  attempts_left,
    output logic [DIGITS-1:0]               an,
    output logic [NIB_W-1:0]                disp_otp_nib,
    output logic [NIB_W-1:0]                disp_user_nib
);

    localparam int unsigned ATT_W = att_w(MAX_ATTEMPTS);
    localparam int unsigned DIG_W = cnt_w(DIGITS);
    localparam int unsigned TMR_W = tmr_w(TIMEOUT_CYC, LOCK_CYC);
    localparam int unsigned OTP_W = NIB_W * DIGITS;

    logic [ST_W-1:0]  state_q, state_d;
    logic [OTP_W-1:0] otp_d, entry_d;
    logic [DIG_W-1:0] digit_cnt_q, digit_cnt_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic [ATT_W-1:0] att_q, att_d;
    logic grant_q, grant_d, fail_q, fail_d, expired_q, expired_d;
    logic locked_q, locked_d, busy_q, busy_d;

    // Session FSM; the one timer serves both the entry timeout and the lockout
    always_comb begin
        state_d     = state_q;
        otp_d       = otp_q;
        entry_d     = entry_q;
        digit_cnt_d = digit_cnt_q;
        timer_d     = timer_q;
        att_d       = att_q;
        grant_d     = 1'b0;
        fail_d      = 1'b0;
        expired_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (otp_latch) begin
                    otp_d       = lfsr_code;
                    entry_d     = '0;
                    digit_cnt_d = '0;
                    timer_d     = '0;
                    state_d     = ST_ENTRY;
                end
            end
            ST_ENTRY: begin
                if (otp_latch) begin
                    // Restart wins over a coincident digit
                    otp_d       = lfsr_code;
                    entry_d     = '0;
                    digit_cnt_d = '0;
                    timer_d     = '0;
                end else if (user_latch) begin
                    for (int i = 0; i < int'(DIGITS); i++) begin
                        if (digit_cnt_q == DIG_W'(i)) begin
                            entry_d[(int'(DIGITS) - 1 - i) * NIB_W +: NIB_W] = user_in;
                        end
                    end
                    timer_d = '0;
                    if (digit_cnt_q == DIG_W'(DIGITS - 1)) begin
                        digit_cnt_d = '0;
                        state_d     = ST_CHECK;
                    end else begin
                        digit_cnt_d = digit_cnt_q + DIG_W'(1);
                    end
                end else if (timer_q == TMR_W'(TIMEOUT_CYC - 1)) begin
                    expired_d   = 1'b1;
                    entry_d     = '0;
                    digit_cnt_d = '0;
                    timer_d     = '0;
                    state_d     = ST_IDLE;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            ST_CHECK: begin
                if (entry_q == otp_q) begin
                    grant_d = 1'b1;
                    state_d = ST_GRANT;
                end else if (att_q > ATT_W'(1)) begin
                    att_d       = att_q - ATT_W'(1);
                    fail_d      = 1'b1;
                    entry_d     = '0;
                    digit_cnt_d = '0;
                    timer_d     = '0;
                    state_d     = ST_ENTRY;
                end else begin
                    // Last attempt used: lock out silently
                    att_d   = '0;
                    timer_d = '0;
                    state_d = ST_LOCKED;
                end
            end
            ST_GRANT: begin
                att_d   = ATT_W'(MAX_ATTEMPTS);
                state_d = ST_IDLE;
            end
            ST_LOCKED: begin
                if (timer_q == TMR_W'(LOCK_CYC - 1)) begin
                    att_d   = ATT_W'(MAX_ATTEMPTS);
                    otp_d   = '0;
                    entry_d = '0;
                    timer_d = '0;
                    state_d = ST_IDLE;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
        busy_d   = (state_d == ST_ENTRY) || (state_d == ST_CHECK);
        locked_d = (state_d == ST_LOCKED);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            otp_q       <= '0;
            entry_q     <= '0;
            digit_cnt_q <= '0;
            timer_q     <= '0;
            att_q       <= ATT_W'(MAX_ATTEMPTS);
            grant_q     <= 1'b0;
            fail_q      <= 1'b0;
            expired_q   <= 1'b0;
            locked_q    <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            otp_q       <= otp_d;
            entry_q     <= entry_d;
            digit_cnt_q <= digit_cnt_d;
            timer_q     <= timer_d;
            att_q       <= att_d;
            grant_q     <= grant_d;
            fail_q      <= fail_d;
            expired_q   <= expired_d;
            locked_q    <= locked_d;
            busy_q      <= busy_d;
        end
    end

    assign grant         = grant_q;
    assign fail          = fail_q;
    assign expired       = expired_q;
    assign locked        = locked_q;
    assign busy          = busy_q;
    assign attempts_left = att_q;

    otp_disp_scan #(
        .DIGITS      (DIGITS),
        .REFRESH_DIV (REFRESH_DIV)
    ) u_disp_scan (
        .clk           (clk),
        .reset_n       (reset_n),
        .otp_in        (otp_q),
        .entry_in      (entry_q),
        .an            (an),
        .disp_otp_nib  (disp_otp_nib),
        .disp_user_nib (disp_user_nib)
    );

endmodule

// File: tb/tb_otp_session_ctrl.sv
// Self-checking bench for otp_session_ctrl: a cycle-level session model is
// compared against every DUT output each cycle, plus directed literal checks.
module tb_otp_session_ctrl;

    localparam int DIGITS = 2;
    localparam int MAXA   = 3;
    localparam int TMO    = 16;
    localparam int LCK    = 32;
    localparam int REF    = 4;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       otp_latch = 1'b0;
    logic       user_latch = 1'b0;
    logic [3:0] user_in = 4'h0;
    logic [7:0] lfsr_code = 8'h00;
    logic [7:0] otp_q, entry_q;
    logic       grant, fail, expired, locked, busy;
    logic [1:0] attempts_left;
    logic [1:0] an;
    logic [3:0] disp_otp_nib, disp_user_nib;

    otp_session_ctrl #(
        .DIGITS(DIGITS), .MAX_ATTEMPTS(MAXA), .TIMEOUT_CYC(TMO),
        .LOCK_CYC(LCK), .REFRESH_DIV(REF)
    ) dut (
        .clk(clk), .reset_n(reset_n), .otp_latch(otp_latch),
        .user_latch(user_latch), .user_in(user_in), .lfsr_code(lfsr_code),
        .otp_q(otp_q), .entry_q(entry_q), .grant(grant), .fail(fail),
        .expired(expired), .locked(locked), .busy(busy),
        .attempts_left(attempts_left), .an(an),
        .disp_otp_nib(disp_otp_nib), .disp_user_nib(disp_user_nib)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- session model ----------------
    // Modes: what the user is doing, not how the DUT encodes it.
    localparam int M_IDLE = 0, M_TYPING = 1, M_JUDGE = 2, M_OK = 3, M_BANNED = 4;

    bit         mvalid = 1'b0;
    int         now = 0;
    int         scan = 0;
    int         mode;
    int         ndig;
    int         deadline;
    logic [7:0] m_otp, m_entry;
    int         e_att;
    logic       e_grant, e_fail, e_exp;
    logic [1:0] e_an;
    logic [3:0] e_onib, e_unib;

    function automatic logic [3:0] digit_of(input logic [7:0] v, input int d);
        logic [7:0] s;
        s = v >> (4 * (DIGITS - 1 - d));
        return s[3:0];
    endfunction

    initial begin
        forever begin
            @(posedge clk);
            now++;
            if (!reset_n) begin
                mvalid  = 1'b1;
                mode    = M_IDLE;
                m_otp   = 8'h00;
                m_entry = 8'h00;
                ndig    = 0;
                e_att   = MAXA;
                e_grant = 1'b0; e_fail = 1'b0; e_exp = 1'b0;
                scan    = 0;
                e_an    = 2'b10;
                e_onib  = 4'h0; e_unib = 4'h0;
            end else begin
                int sel;
                scan++;
                sel    = (scan / REF) % DIGITS;
                e_an   = 2'b11;
                e_an[sel] = 1'b0;
                e_onib = digit_of(m_otp, sel);
                e_unib = digit_of(m_entry, sel);
                e_grant = 1'b0; e_fail = 1'b0; e_exp = 1'b0;
                case (mode)
                    M_IDLE, M_TYPING: begin
                        if (otp_latch) begin
                            m_otp = lfsr_code; m_entry = 8'h00; ndig = 0;
                            deadline = now + TMO; mode = M_TYPING;
                        end else if (mode == M_TYPING && user_latch) begin
                            m_entry = m_entry | (8'(user_in) << (4 * (DIGITS - 1 - ndig)));
                            ndig++;
                            deadline = now + TMO;
                            if (ndig == DIGITS) mode = M_JUDGE;
                        end else if (mode == M_TYPING && now == deadline) begin
                            e_exp = 1'b1; m_entry = 8'h00; mode = M_IDLE;
                        end
                    end
                    M_JUDGE: begin
                        if (m_entry == m_otp) begin
                            e_grant = 1'b1; mode = M_OK;
                        end else if (e_att > 1) begin
                            e_att--; e_fail = 1'b1; m_entry = 8'h00; ndig = 0;
                            deadline = now + TMO; mode = M_TYPING;
                        end else begin
                            e_att = 0; deadline = now + LCK; mode = M_BANNED;
                        end
                    end
                    M_OK: begin
                        e_att = MAXA; mode = M_IDLE;
                    end
                    default: begin
                        if (now == deadline) begin
                            e_att = MAXA; m_otp = 8'h00; m_entry = 8'h00; mode = M_IDLE;
                        end
                    end
                endcase
            end
        end
    end

    // Per-cycle comparison, away from the active edge
    initial begin
        forever begin
            @(negedge clk);
            if (mvalid) begin
                check("otp_q", 32'(otp_q), 32'(m_otp));
                check("entry_q", 32'(entry_q), 32'(m_entry));
                check("grant", 32'(grant), 32'(e_grant));
                check("fail", 32'(fail), 32'(e_fail));
                check("expired", 32'(expired), 32'(e_exp));
                check("locked", 32'(locked), 32'(mode == M_BANNED));
                check("busy", 32'(busy), 32'(mode == M_TYPING || mode == M_JUDGE));
                check("attempts_left", 32'(attempts_left), 32'(e_att));
                check("an", 32'(an), 32'(e_an));
                check("disp_otp_nib", 32'(disp_otp_nib), 32'(e_onib));
                check("disp_user_nib", 32'(disp_user_nib), 32'(e_unib));
                check("pulse_onehot", 32'(int'(grant) + int'(fail) + int'(expired) <= 1), 32'd1);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    // ---------------- stimulus (each task starts and ends on a negedge) ----
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic give_otp(input logic [7:0] code);
        otp_latch = 1'b1; lfsr_code = code;
        @(negedge clk);
        otp_latch = 1'b0;
    endtask

    task automatic give_digit(input logic [3:0] d);
        user_latch = 1'b1; user_in = d;
        @(negedge clk);
        user_latch = 1'b0;
    endtask

    initial begin
        int n;
        tick(2);
        check("rst_an", 32'(an), 32'h2);
        check("rst_att", 32'(attempts_left), 32'd3);
        reset_n = 1'b1;
        tick(1);

        // Correct entry A5
        give_otp(8'hA5);
        check("t1_otp", 32'(otp_q), 32'hA5);
        give_digit(4'hA);
        give_digit(4'h5);
        check("t1_no_grant_yet", 32'(grant), 32'd0);
        tick(1);
        check("t1_grant", 32'(grant), 32'd1);
        tick(1);
        check("t1_grant_gone", 32'(grant), 32'd0);
        check("t1_att", 32'(attempts_left), 32'd3);
        check("t1_busy", 32'(busy), 32'd0);
        // Display scan of A5
        for (int k = 0; k < 10; k++) begin
            if (an == 2'b10) check("scan_d0", 32'(disp_otp_nib), 32'hA);
            else             check("scan_d1", 32'(disp_otp_nib), 32'h5);
            check("scan_user", 32'(disp_user_nib), 32'(disp_otp_nib));
            tick(1);
        end

        // Three wrong entries against 3C
        give_otp(8'h3C);
        give_digit(4'h3); give_digit(4'hD); tick(1);
        check("t2_fail1", 32'(fail), 32'd1);
        check("t2_att2", 32'(attempts_left), 32'd2);
        give_digit(4'h0); give_digit(4'h0); tick(1);
        check("t2_fail2", 32'(fail), 32'd1);
        check("t2_att1", 32'(attempts_left), 32'd1);
        give_digit(4'hF); give_digit(4'hF); tick(1);
        check("t2_locked", 32'(locked), 32'd1);
        check("t2_nofail", 32'(fail), 32'd0);
        check("t2_att0", 32'(attempts_left), 32'd0);
        n = 0;
        while (locked && n < 40) begin
            n++;
            otp_latch  = (n == 3);
            user_latch = (n == 3) || (n == 5);
            lfsr_code  = 8'h11; user_in = 4'h1;
            @(negedge clk);
            if (n == 6) check("t2_otp_held", 32'(otp_q), 32'h3C);
        end
        otp_latch = 1'b0; user_latch = 1'b0;
        check("t2_lock_len", 32'(n), 32'd32);
        check("t2_unlocked_att", 32'(attempts_left), 32'd3);
        check("t2_unlocked_otp", 32'(otp_q), 32'h00);
        tick(1);

        // Timeout after one digit
        give_otp(8'h5A);
        give_digit(4'h5);
        tick(15);
        check("t3_not_yet", 32'(expired), 32'd0);
        tick(1);
        check("t3_expired", 32'(expired), 32'd1);
        check("t3_entry", 32'(entry_q), 32'h00);
        check("t3_busy", 32'(busy), 32'd0);
        check("t3_att", 32'(attempts_left), 32'd3);
        tick(1);

        // Simultaneous otp_latch + user_latch during entry
        give_otp(8'h12);
        give_digit(4'h1);
        otp_latch = 1'b1; lfsr_code = 8'h77; user_latch = 1'b1; user_in = 4'h9;
        tick(1);
        otp_latch = 1'b0; user_latch = 1'b0;
        check("t4_otp", 32'(otp_q), 32'h77);
        check("t4_entry", 32'(entry_q), 32'h00);
        give_digit(4'h7); give_digit(4'h7); tick(1);
        check("t4_grant", 32'(grant), 32'd1);
        tick(2);

        // Mid-session reset after a failed attempt and one digit
        give_otp(8'hA5);
        give_digit(4'h0); give_digit(4'h0); tick(1);
        check("t5_att2", 32'(attempts_left), 32'd2);
        give_digit(4'hA);
        reset_n = 1'b0;
        tick(1);
        reset_n = 1'b1;
        check("t5_otp", 32'(otp_q), 32'h00);
        check("t5_entry", 32'(entry_q), 32'h00);
        check("t5_busy", 32'(busy), 32'd0);
        check("t5_att", 32'(attempts_left), 32'd3);
        check("t5_an", 32'(an), 32'h2);
        tick(20);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
